// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
//
// Multi-player score counter for the game datapath. Counts hit events per
// player, declares a winner (with tie reporting) as soon as any player reaches
// TARGET, and holds the result until NEW_GAME, or until an optional
// auto-restart interval expires.
//
// Parameters
//   NUM_PLAYERS  number of players (>= 2)
//   TARGET       winning score, 1 .. 2**CNT_W-1
//   CNT_W        per-player score width
//   EDGE_MODE    1: count rising edges of HIT[i]; 0: count every high cycle
//   HOLD_CYCLES  0: hold the result until NEW_GAME; >0: auto-restart after
//                this many cycles in OVER
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset, overrides everything
//   HIT       in   per-player hit inputs
//   NEW_GAME  in   clears scores and result, returns to PLAY
//   GAMEOVER  out  high while a result is held
//   WHO       out  0 = no winner, i+1 = player i won (lowest index on a tie)
//   TIE       out  more than one player reached TARGET on the winning edge
//   SCORES    out  packed scores, player i at [i*CNT_W +: CNT_W]
//
// All outputs are registered; there is no combinational input->output path.
// -----------------------------------------------------------------------------
module score_keeper #(
  parameter int NUM_PLAYERS = 2,
  parameter int TARGET      = 15,
  parameter int CNT_W       = 4,
  parameter int EDGE_MODE   = 1,
  parameter int HOLD_CYCLES = 0,
  localparam int WHO_W      = $clog2(NUM_PLAYERS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PLAYERS-1:0]       HIT,
  input  logic                         NEW_GAME,
  output logic                         GAMEOVER,
  output logic [WHO_W-1:0]             WHO,
  output logic                         TIE,
  output logic [NUM_PLAYERS*CNT_W-1:0] SCORES
);

  // Hold counter is never narrower than one bit so the HOLD_CYCLES=0 build
  // still has a well-formed (if idle) register.
  localparam int HC_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TARGET_M1 = CNT_W'(TARGET - 1);
  localparam logic [HC_W-1:0]  HC_ONE    = HC_W'(1);
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'((HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0);

  typedef enum logic {
    ST_PLAY = 1'b0,
    ST_OVER = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [HC_W-1:0]        hold_q, hold_d;
  logic [NUM_PLAYERS-1:0] hit_q;
  logic [CNT_W-1:0]       score_q [NUM_PLAYERS];
  logic [CNT_W-1:0]       score_d [NUM_PLAYERS];
  logic                   gameover_q, gameover_d;
  logic [WHO_W-1:0]       who_q, who_d;
  logic                   tie_q, tie_d;

  logic [NUM_PLAYERS-1:0] ev;
  logic [NUM_PLAYERS-1:0] reached;
  logic                   win_any;
  logic [WHO_W-1:0]       who_sel;
  logic                   tie_sel;
  logic                   found;
  logic                   restart;

  // Event detection. hit_q tracks HIT in every state, so a HIT held across a
  // restart does not look like a fresh edge in EDGE_MODE.
  always_comb begin
    if (EDGE_MODE != 0) begin
      ev = HIT & ~hit_q;
    end else begin
      ev = HIT;
    end
  end

  // A player reaches TARGET when it has an event while sitting one below it.
  // Scores never pass TARGET, so equality with TARGET-1 is sufficient.
  always_comb begin
    reached = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      reached[i] = ev[i] && (score_q[i] == TARGET_M1);
    end
  end

  assign win_any = |reached;

  // Lowest-index winner reports in WHO; any further winner flags the tie.
  always_comb begin
    who_sel = '0;
    tie_sel = 1'b0;
    found   = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (reached[i]) begin
        if (!found) begin
          who_sel = WHO_W'(i + 1);
          found   = 1'b1;
        end else begin
          tie_sel = 1'b1;
        end
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    score_d    = score_q;
    gameover_d = gameover_q;
    who_d      = who_q;
    tie_d      = tie_q;
    restart    = 1'b0;

    case (state_q)
      ST_PLAY: begin
        if (NEW_GAME) begin
          // Events on the NEW_GAME cycle are discarded.
          restart = 1'b1;
        end else begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (ev[i]) begin
              score_d[i] = score_q[i] + CNT_ONE;
            end
          end
          if (win_any) begin
            state_d    = ST_OVER;
            gameover_d = 1'b1;
            who_d      = who_sel;
            tie_d      = tie_sel;
            hold_d     = '0;
          end
        end
      end

      ST_OVER: begin
        // Scores, WHO and TIE are frozen; events are ignored.
        if (NEW_GAME) begin
          restart = 1'b1;
        end else if (HOLD_CYCLES > 0) begin
          // Counter enters at 0 on the winning edge, so clearing on the edge
          // where it reads HOLD_CYCLES-1 keeps GAMEOVER high exactly
          // HOLD_CYCLES cycles.
          if (hold_q == HOLD_LAST) begin
            restart = 1'b1;
          end else begin
            hold_d = hold_q + HC_ONE;
          end
        end
      end

      default: begin
        restart = 1'b1;
      end
    endcase

    if (restart) begin
      state_d    = ST_PLAY;
      hold_d     = '0;
      score_d    = '{default: '0};
      gameover_d = 1'b0;
      who_d      = '0;
      tie_d      = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_PLAY;
      hold_q     <= '0;
      hit_q      <= '0;
      score_q    <= '{default: '0};
      gameover_q <= 1'b0;
      who_q      <= '0;
      tie_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hit_q      <= HIT;
      score_q    <= score_d;
      gameover_q <= gameover_d;
      who_q      <= who_d;
      tie_q      <= tie_d;
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
    assign SCORES[g*CNT_W +: CNT_W] = score_q[g];
  end

  assign GAMEOVER = gameover_q;
  assign WHO      = who_q;
  assign TIE      = tie_q;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

  logic clk;
  logic rst;

  // a: 2 players, TARGET 15, edge mode, hold until NEW_GAME
  logic [1:0]  hit_a;
  logic        ng_a;
  logic        go_a;
  logic [1:0]  who_a;
  logic        tie_a;
  logic [7:0]  sc_a;

  // b: same as a but level counting
  logic [1:0]  hit_b;
  logic        ng_b;
  logic        go_b;
  logic [1:0]  who_b;
  logic        tie_b;
  logic [7:0]  sc_b;

  // c: 4 players, TARGET 3
  logic [3:0]  hit_c;
  logic        ng_c;
  logic        go_c;
  logic [2:0]  who_c;
  logic        tie_c;
  logic [15:0] sc_c;

  // d: 2 players, TARGET 2, auto-restart after 4 cycles
  logic [1:0]  hit_d;
  logic        ng_d;
  logic        go_d;
  logic [1:0]  who_d;
  logic        tie_d;
  logic [7:0]  sc_d;

  score_keeper #(.NUM_PLAYERS(2), .TARGET(15), .CNT_W(4), .EDGE_MODE(1), .HOLD_CYCLES(0)) u_a (
    .clk(clk), .rst(rst), .HIT(hit_a), .NEW_GAME(ng_a),
    .GAMEOVER(go_a), .WHO(who_a), .TIE(tie_a), .SCORES(sc_a));

  score_keeper #(.NUM_PLAYERS(2), .TARGET(15), .CNT_W(4), .EDGE_MODE(0), .HOLD_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .HIT(hit_b), .NEW_GAME(ng_b),
    .GAMEOVER(go_b), .WHO(who_b), .TIE(tie_b), .SCORES(sc_b));

  score_keeper #(.NUM_PLAYERS(4), .TARGET(3), .CNT_W(4), .EDGE_MODE(1), .HOLD_CYCLES(0)) u_c (
    .clk(clk), .rst(rst), .HIT(hit_c), .NEW_GAME(ng_c),
    .GAMEOVER(go_c), .WHO(who_c), .TIE(tie_c), .SCORES(sc_c));

  score_keeper #(.NUM_PLAYERS(2), .TARGET(2), .CNT_W(4), .EDGE_MODE(1), .HOLD_CYCLES(4)) u_d (
    .clk(clk), .rst(rst), .HIT(hit_d), .NEW_GAME(ng_d),
    .GAMEOVER(go_d), .WHO(who_d), .TIE(tie_d), .SCORES(sc_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dut;
    string       tag;
    logic [15:0] sc;
    logic        go;
    logic [2:0]  who;
    logic        tie;
  } exp_t;

  exp_t sbq[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic logic [15:0] obs_sc(int d);
    case (d)
      0:       return {8'h00, sc_a};
      1:       return {8'h00, sc_b};
      2:       return sc_c;
      default: return {8'h00, sc_d};
    endcase
  endfunction

  function automatic logic obs_go(int d);
    case (d)
      0:       return go_a;
      1:       return go_b;
      2:       return go_c;
      default: return go_d;
    endcase
  endfunction

  function automatic logic [2:0] obs_who(int d);
    case (d)
      0:       return {1'b0, who_a};
      1:       return {1'b0, who_b};
      2:       return who_c;
      default: return {1'b0, who_d};
    endcase
  endfunction

  function automatic logic obs_tie(int d);
    case (d)
      0:       return tie_a;
      1:       return tie_b;
      2:       return tie_c;
      default: return tie_d;
    endcase
  endfunction

  // Record what a DUT must show after the next active edge.
  task automatic expect_out(input int d, input string tag, input logic [15:0] sc,
                            input logic go, input logic [2:0] who, input logic tie);
    exp_t e;
    e.dut = d; e.tag = tag; e.sc = sc; e.go = go; e.who = who; e.tie = tie;
    sbq.push_back(e);
  endtask

  // Advance one edge, then compare every pending expectation.
  task automatic tick_check();
    exp_t        e;
    logic [15:0] osc;
    logic        ogo;
    logic [2:0]  owho;
    logic        otie;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e    = sbq.pop_front();
      osc  = obs_sc(e.dut);
      ogo  = obs_go(e.dut);
      owho = obs_who(e.dut);
      otie = obs_tie(e.dut);
      n_assert++;
      assert (osc === e.sc) else begin
        n_fail++;
        $error("FAIL %s scores: observed %h expected %h", e.tag, osc, e.sc);
      end
      n_assert++;
      assert (ogo === e.go) else begin
        n_fail++;
        $error("FAIL %s gameover: observed %b expected %b", e.tag, ogo, e.go);
      end
      n_assert++;
      assert (owho === e.who) else begin
        n_fail++;
        $error("FAIL %s who: observed %0d expected %0d", e.tag, owho, e.who);
      end
      n_assert++;
      assert (otie === e.tie) else begin
        n_fail++;
        $error("FAIL %s tie: observed %b expected %b", e.tag, otie, e.tie);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    hit_a = '0; ng_a = 1'b0;
    hit_b = '0; ng_b = 1'b0;
    hit_c = '0; ng_c = 1'b0;
    hit_d = '0; ng_d = 1'b0;

    // Reset state, in reset and on the first free-running cycle
    for (int d = 0; d < 4; d++) expect_out(d, "reset", 16'h0, 1'b0, 3'd0, 1'b0);
    tick_check();
    rst = 1'b0;
    for (int d = 0; d < 4; d++) expect_out(d, "post_reset", 16'h0, 1'b0, 3'd0, 1'b0);
    tick_check();

    // Basic count to win: player 1, fifteen separated pulses
    for (int k = 1; k <= 15; k++) begin
      hit_a = 2'b10;
      expect_out(0, $sformatf("a_cnt%0d", k), {8'h00, 4'(k), 4'h0},
                 (k == 15), (k == 15) ? 3'd2 : 3'd0, 1'b0);
      tick_check();
      hit_a = 2'b00;
      expect_out(0, $sformatf("a_low%0d", k), {8'h00, 4'(k), 4'h0},
                 (k == 15), (k == 15) ? 3'd2 : 3'd0, 1'b0);
      tick_check();
    end
    hit_a = 2'b11;
    expect_out(0, "a_over_hit", 16'h00F0, 1'b1, 3'd2, 1'b0);
    tick_check();
    hit_a = 2'b00;
    expect_out(0, "a_over_low", 16'h00F0, 1'b1, 3'd2, 1'b0);
    tick_check();
    ng_a = 1'b1;
    expect_out(0, "a_newgame", 16'h0000, 1'b0, 3'd0, 1'b0);
    tick_check();
    ng_a = 1'b0;

    // NEW_GAME mid-game with score 7 and a concurrent hit
    for (int k = 1; k <= 7; k++) begin
      hit_a = 2'b01;
      expect_out(0, $sformatf("a_p0_%0d", k), {12'h000, 4'(k)}, 1'b0, 3'd0, 1'b0);
      tick_check();
      hit_a = 2'b00;
      tick_check();
    end
    ng_a  = 1'b1;
    hit_a = 2'b01;
    expect_out(0, "a_ng_with_hit", 16'h0000, 1'b0, 3'd0, 1'b0);
    tick_check();
    ng_a  = 1'b0;
    hit_a = 2'b00;
    expect_out(0, "a_ng_after", 16'h0000, 1'b0, 3'd0, 1'b0);
    tick_check();
    hit_a = 2'b01;
    expect_out(0, "a_first_after_ng", 16'h0001, 1'b0, 3'd0, 1'b0);
    tick_check();
    hit_a = 2'b00;
    ng_a  = 1'b1;
    expect_out(0, "a_clear2", 16'h0000, 1'b0, 3'd0, 1'b0);
    tick_check();
    ng_a = 1'b0;

    // Edge vs level: HIT[0] held for 5 cycles
    for (int k = 1; k <= 5; k++) begin
      hit_a = 2'b01;
      hit_b = 2'b01;
      expect_out(0, $sformatf("edge_hold%0d", k), 16'h0001, 1'b0, 3'd0, 1'b0);
      expect_out(1, $sformatf("level_hold%0d", k), {12'h000, 4'(k)}, 1'b0, 3'd0, 1'b0);
      tick_check();
    end
    hit_a = 2'b00;
    hit_b = 2'b00;
    expect_out(0, "edge_final", 16'h0001, 1'b0, 3'd0, 1'b0);
    expect_out(1, "level_final", 16'h0005, 1'b0, 3'd0, 1'b0);
    tick_check();

    // Simultaneous events and a tied win on the 4-player instance
    hit_c = 4'b0101;
    expect_out(2, "c_p0p2", 16'h0101, 1'b0, 3'd0, 1'b0);
    tick_check();
    hit_c = 4'b0000;
    tick_check();
    hit_c = 4'b1010;
    expect_out(2, "c_p1p3_1", 16'h1111, 1'b0, 3'd0, 1'b0);
    tick_check();
    hit_c = 4'b0000;
    tick_check();
    hit_c = 4'b1010;
    expect_out(2, "c_p1p3_2", 16'h2121, 1'b0, 3'd0, 1'b0);
    tick_check();
    hit_c = 4'b0000;
    tick_check();
    hit_c = 4'b1010;
    expect_out(2, "c_tie_win", 16'h3131, 1'b1, 3'd2, 1'b1);
    tick_check();
    hit_c = 4'b0000;
    expect_out(2, "c_tie_hold", 16'h3131, 1'b1, 3'd2, 1'b1);
    tick_check();
    hit_c = 4'b0101;
    expect_out(2, "c_over_ignore", 16'h3131, 1'b1, 3'd2, 1'b1);
    tick_check();

    // One-cycle reset while in OVER (resets every instance)
    rst   = 1'b1;
    hit_c = 4'b1111;
    expect_out(2, "c_rst_over", 16'h0000, 1'b0, 3'd0, 1'b0);
    expect_out(0, "a_rst", 16'h0000, 1'b0, 3'd0, 1'b0);
    expect_out(1, "b_rst", 16'h0000, 1'b0, 3'd0, 1'b0);
    tick_check();
    rst   = 1'b0;
    hit_c = 4'b0010;
    expect_out(2, "c_play_after_rst", 16'h0010, 1'b0, 3'd0, 1'b0);
    tick_check();
    hit_c = 4'b0000;
    tick_check();

    // HOLD_CYCLES=0: result held through random activity
    for (int k = 1; k <= 3; k++) begin
      hit_c = 4'b0001;
      expect_out(2, $sformatf("c_p0_%0d", k), {12'h001, 4'(k)},
                 (k == 3), (k == 3) ? 3'd1 : 3'd0, 1'b0);
      tick_check();
      hit_c = 4'b0000;
      tick_check();
    end
    for (int k = 0; k < 100; k++) begin
      hit_c = 4'($urandom_range(0, 15));
      expect_out(2, $sformatf("c_held%0d", k), 16'h0013, 1'b1, 3'd1, 1'b0);
      tick_check();
    end
    hit_c = 4'b0000;
    ng_c  = 1'b1;
    expect_out(2, "c_ng_clear", 16'h0000, 1'b0, 3'd0, 1'b0);
    tick_check();
    ng_c = 1'b0;

    // Auto restart after 4 cycles, HIT held across the restart
    hit_d = 2'b01;
    expect_out(3, "d_p0_1", 16'h0001, 1'b0, 3'd0, 1'b0);
    tick_check();
    hit_d = 2'b00;
    tick_check();
    hit_d = 2'b01;
    expect_out(3, "d_win", 16'h0002, 1'b1, 3'd1, 1'b0);
    tick_check();
    for (int k = 2; k <= 4; k++) begin
      expect_out(3, $sformatf("d_hold%0d", k), 16'h0002, 1'b1, 3'd1, 1'b0);
      tick_check();
    end
    expect_out(3, "d_restart", 16'h0000, 1'b0, 3'd0, 1'b0);
    tick_check();
    expect_out(3, "d_held_hit", 16'h0000, 1'b0, 3'd0, 1'b0);
    tick_check();
    hit_d = 2'b00;
    expect_out(3, "d_low", 16'h0000, 1'b0, 3'd0, 1'b0);
    tick_check();
    hit_d = 2'b01;
    expect_out(3, "d_new_edge", 16'h0001, 1'b0, 3'd0, 1'b0);
    tick_check();
    hit_d = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
